// File: rtl/mem_req_arbiter_pkg.sv
// Shared constants and state encodings for the memory request arbiter.
package mem_req_arbiter_pkg;

    localparam logic TRUE       = 1'b1;
    localparam logic FALSE      = 1'b0;
    localparam logic FLAG_READ  = 1'b0;
    localparam logic FLAG_WRITE = 1'b1;

    localparam int unsigned ADDR_LEN = 32;
    localparam int unsigned DATA_LEN = 32;

    localparam logic [ADDR_LEN-1:0] ZERO_ADDR = '0;

    localparam logic [2:0] SIZE_BYTE = 3'd1;
    localparam logic [2:0] SIZE_HALF = 3'd2;
    localparam logic [2:0] SIZE_WORD = 3'd4;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY_IF = 2'd1,
        ARB_BUSY_LS = 2'd2,
        ARB_DRAIN   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_req_arbiter_req_slot.sv
// One-entry request holding register with capture, grant-clear and flush-clear.
module req_slot #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             capture,
    input  logic             clear,
    input  logic             flush_clr,
    input  logic [WIDTH-1:0] din,
    output logic             valid,
    output logic [WIDTH-1:0] dout
);

    // Flush beats capture; capture only lands in an empty slot, clear only hits a full one.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (rdy) begin
            if (flush_clr) begin
                valid <= 1'b0;
            end else if (capture && !valid) begin
                valid <= 1'b1;
                dout  <= din;
            end else if (clear) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates fetch and load/store requests onto the single memory controller port.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_LEN     = mem_req_arbiter_pkg::ADDR_LEN,
    parameter int unsigned DATA_LEN     = mem_req_arbiter_pkg::DATA_LEN,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                flush,
    input  logic                if_req_valid,
    input  logic [ADDR_LEN-1:0] if_req_addr,
    output logic                if_req_ready,
    output logic                if_resp_valid,
    output logic [DATA_LEN-1:0] if_resp_data,
    input  logic                ls_req_valid,
    input  logic                ls_req_wr,
    input  logic [2:0]          ls_req_size,
    input  logic [ADDR_LEN-1:0] ls_req_addr,
    input  logic [DATA_LEN-1:0] ls_req_wdata,
    output logic                ls_req_ready,
    output logic                ls_resp_valid,
    output logic [DATA_LEN-1:0] ls_resp_data,
    output logic                mc_ena,
    output logic                mc_wr_flag,
    output logic [2:0]          mc_size,
    output logic [ADDR_LEN-1:0] mc_addr,
    output logic [DATA_LEN-1:0] mc_wdata,
    input  logic                mc_ok,
    input  logic [DATA_LEN-1:0] mc_rdata
);

    localparam int unsigned STREAK_W = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned LS_W     = 1 + 3 + ADDR_LEN + DATA_LEN;

    logic                if_slot_valid;
    logic [ADDR_LEN-1:0] if_slot_addr;
    logic                ls_slot_valid;
    logic [LS_W-1:0]     ls_slot_data;
    logic                ls_slot_wr;
    logic [2:0]          ls_slot_size;
    logic [ADDR_LEN-1:0] ls_slot_addr;
    logic [DATA_LEN-1:0] ls_slot_wdata;

    arb_state_e          state_q, state_d;
    logic [STREAK_W-1:0] streak_q;
    logic                grant_if, grant_ls, if_done, ls_done;
    logic                fetch_cand, starved;

    assign {ls_slot_wr, ls_slot_size, ls_slot_addr, ls_slot_wdata} = ls_slot_data;

    // Fetch slot: a flush drops its content and blocks a same-cycle capture.
    req_slot #(.WIDTH(ADDR_LEN)) u_if_slot (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .capture   (if_req_valid && !flush),
        .clear     (grant_if),
        .flush_clr (flush),
        .din       (if_req_addr),
        .valid     (if_slot_valid),
        .dout      (if_slot_addr)
    );

    // Load/store slot: never flushed, stores must complete.
    req_slot #(.WIDTH(LS_W)) u_ls_slot (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .capture   (ls_req_valid),
        .clear     (grant_ls),
        .flush_clr (1'b0),
        .din       ({ls_req_wr, ls_req_size, ls_req_addr, ls_req_wdata}),
        .valid     (ls_slot_valid),
        .dout      (ls_slot_data)
    );

    assign if_req_ready = !if_slot_valid;
    assign ls_req_ready = !ls_slot_valid;

    // Keep only the low bytes a load of the given size actually returns.
    function automatic logic [DATA_LEN-1:0] mask_bytes(input logic [DATA_LEN-1:0] d,
                                                       input logic [2:0] sz);
        case (sz)
            SIZE_BYTE: return DATA_LEN'(d[7:0]);
            SIZE_HALF: return DATA_LEN'(d[15:0]);
            default:   return d;
        endcase
    endfunction

    // Next-state and grant decode.
    always_comb begin
        state_d    = state_q;
        grant_if   = FALSE;
        grant_ls   = FALSE;
        if_done    = FALSE;
        ls_done    = FALSE;
        fetch_cand = if_slot_valid && !flush;
        starved    = fetch_cand && (streak_q == STREAK_W'(STARVE_LIMIT));
        case (state_q)
            ARB_IDLE: begin
                if (ls_slot_valid && !starved) begin
                    grant_ls = TRUE;
                    state_d  = ARB_BUSY_LS;
                end else if (fetch_cand) begin
                    grant_if = TRUE;
                    state_d  = ARB_BUSY_IF;
                end
            end
            ARB_BUSY_IF: begin
                if (mc_ok) begin
                    if_done = !flush;
                    state_d = ARB_IDLE;
                end else if (flush) begin
                    state_d = ARB_DRAIN;
                end
            end
            ARB_BUSY_LS: begin
                if (mc_ok) begin
                    ls_done = TRUE;
                    state_d = ARB_IDLE;
                end
            end
            ARB_DRAIN: begin
                if (mc_ok) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else if (rdy) begin
            state_q <= state_d;
        end
    end

    // Count LS grants that pass over a waiting fetch; saturates at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q <= '0;
        end else if (rdy) begin
            if (grant_if || !fetch_cand) begin
                streak_q <= '0;
            end else if (grant_ls && (streak_q != STREAK_W'(STARVE_LIMIT))) begin
                streak_q <= streak_q + STREAK_W'(1);
            end
        end
    end

    // Registered issue fields and completion responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            mc_ena        <= FALSE;
            mc_wr_flag    <= FLAG_READ;
            mc_size       <= '0;
            mc_addr       <= ADDR_LEN'(ZERO_ADDR);
            mc_wdata      <= '0;
            if_resp_valid <= FALSE;
            if_resp_data  <= '0;
            ls_resp_valid <= FALSE;
            ls_resp_data  <= '0;
        end else if (!rdy) begin
            mc_ena        <= FALSE;
            if_resp_valid <= FALSE;
            ls_resp_valid <= FALSE;
        end else begin
            mc_ena <= grant_if || grant_ls;
            if (grant_ls) begin
                mc_wr_flag <= ls_slot_wr;
                mc_size    <= ls_slot_size;
                mc_addr    <= ls_slot_addr;
                mc_wdata   <= ls_slot_wdata;
            end else if (grant_if) begin
                mc_wr_flag <= FLAG_READ;
                mc_size    <= SIZE_WORD;
                mc_addr    <= if_slot_addr;
                mc_wdata   <= '0;
            end
            if_resp_valid <= if_done;
            if (if_done) begin
                if_resp_data <= mc_rdata;
            end
            ls_resp_valid <= ls_done;
            if (ls_done) begin
                ls_resp_data <= (mc_wr_flag == FLAG_WRITE) ? '0 : mask_bytes(mc_rdata, mc_size);
            end
        end
    end

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

- Shares the single request port of the byte-serial memory controller between the instruction fetcher and the load/store executor.
- Holds one pending request per requester and grants with load/store priority plus a starvation bound for fetch.
- Sequences exactly one memory transaction at a time and routes the completion back to its owner.
- On a branch flush, drops a pending fetch and silently drains an in-flight fetch.

## Interface
Parameters:
- ADDR_LEN, 32, address width
- DATA_LEN, 32, data width
- STARVE_LIMIT, 4, consecutive LS grants while fetch waits before fetch is forced

Ports (`clk`, `rst`: one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; low = hold all state
- flush  in  1  mispredict flush, one-cycle pulse
- if_req_valid  in  1  fetch request
- if_req_addr  in  ADDR_LEN  fetch PC
- if_req_ready  out  1  fetch slot empty
- if_resp_valid  out  1  fetch done, one-cycle pulse
- if_resp_data  out  DATA_LEN  instruction
- ls_req_valid  in  1  load/store request
- ls_req_wr  in  1  1 = store, 0 = load
- ls_req_size  in  3  bytes: 1, 2 or 4
- ls_req_addr  in  ADDR_LEN  byte address
- ls_req_wdata  in  DATA_LEN  store data
- ls_req_ready  out  1  LS slot empty
- ls_resp_valid  out  1  LS done, one-cycle pulse
- ls_resp_data  out  DATA_LEN  load data, zero above size
- mc_ena  out  1  issue strobe to memory controller, one-cycle pulse
- mc_wr_flag  out  1  write flag
- mc_size  out  3  bytes
- mc_addr  out  ADDR_LEN  address
- mc_wdata  out  DATA_LEN  store data
- mc_ok  in  1  controller completion pulse
- mc_rdata  in  DATA_LEN  assembled read data

## Operation
- Request slots:
  - A request is accepted when valid && ready at a rising edge; it is captured into its slot.
  - `if_req_ready` = !if_slot_valid. `ls_req_ready` = !ls_slot_valid. Both are driven from registers.
- States: IDLE, BUSY_IF, BUSY_LS, DRAIN.
- IDLE:
  - If any slot is valid, select one.
  - Drive the `mc_*` fields and pulse `mc_ena` for one cycle.
  - Clear the selected slot and go to BUSY_IF or BUSY_LS.
- Selection:
  - LS wins when both slots are valid.
  - Exception: fetch wins when streak == STARVE_LIMIT.
- streak:
  - +1 on each LS grant made while the fetch slot is valid, saturating at STARVE_LIMIT.
  - Cleared on every fetch grant, and whenever the fetch slot is empty.
- BUSY_IF + mc_ok: pulse `if_resp_valid`, set `if_resp_data` = mc_rdata, go to IDLE.
- BUSY_LS + mc_ok: pulse `ls_resp_valid` and go to IDLE.
  - `ls_resp_data` = mc_rdata masked to the low `ls_req_size` bytes (1 → [7:0], 2 → [15:0], 4 → full).
  - Stores also return `ls_resp_valid`; data is 0.
- Flush (sampled when rdy=1):
  - Clears the fetch slot.
  - A simultaneous `if_req_valid` is not accepted.
  - BUSY_IF → DRAIN.
  - DRAIN + mc_ok → IDLE with no response.
  - The LS slot and BUSY_LS are unaffected (stores must complete).
- The fetch slot may accept a new request while in DRAIN; it issues after the drain completes.
- mc_ok in IDLE is ignored.
- Fetch issues use `mc_wr_flag`=0, `mc_size`=4, `mc_wdata`=0.

## Timing
- Reset values: every output 0 except both ready outputs = 1. State IDLE, slots empty, streak 0.
- Pulse outputs (`mc_ena`, `*_resp_valid`) default to 0 at every edge.
- Request captured at edge E0 → `mc_ena` high in the cycle after edge E1, assuming IDLE at E1. Minimum issue latency is 1 cycle after capture.
- mc_ok sampled at edge Ek → resp_valid high for the cycle after Ek. State is IDLE after Ek, so the next `mc_ena` follows Ek+1.
- Throughput: one transaction in flight; no back-to-back issue without a completion.
- rdy=0: all registers hold, pulses deassert, inputs ignored. The controller is frozen by the same rdy.
- rst mid-transaction: immediate return to the reset values, and any in-flight completion is lost. The controller is reset by the same rst.
- Ready outputs update the cycle after capture or issue; a slot can refill on the edge after it is granted.

## Structure
- Shared defines header entries:
  - TRUE/FALSE, FLAG_READ/FLAG_WRITE
  - ZERO_ADDR
  - ADDR_LEN/DATA_LEN
  - arbiter state encodings ARB_IDLE/ARB_BUSY_IF/ARB_BUSY_LS/ARB_DRAIN
- Sub-module `req_slot`: one-entry holding register with valid, capture, clear and flush-clear.
  - Instantiated twice: fetch with {addr}; LS with {wr, size, addr, wdata}.
- Arbitration, FSM, streak counter and response masking live in the top module.

## Test plan
- Single fetch 0x1000, mc_ok 5 cycles later with 0x00500093:
  - `mc_ena` one cycle with `mc_addr`=0x1000, `mc_size`=4.
  - `if_resp_valid` one cycle, `if_resp_data`=0x00500093.
- Fetch and LS load (addr 0x20, size 1) valid the same edge, mc_rdata=0xDEADBEEF:
  - LS issued first.
  - `ls_resp_data`=0x000000EF.
  - Fetch issued after.
- Fetch held pending while LS requests stream continuously, STARVE_LIMIT=4:
  - Exactly 4 LS grants, then the fetch grant.
  - streak returns to 0.
- Flush during BUSY_IF:
  - DRAIN entered.
  - mc_ok yields no `if_resp_valid`.
  - A new fetch 0x2000 accepted in DRAIN issues after mc_ok.
- Flush coincident with `if_req_valid` and a pending LS store (size 4, 0x12345678 to 0x30):
  - Fetch dropped, `if_req_ready`=1.
  - Store issues with `mc_wr_flag`=1, `mc_wdata`=0x12345678.
  - `ls_resp_valid` pulses.
- rdy low for 3 cycles mid-BUSY_LS, then rst asserted in BUSY_LS:
  - State, slots and `mc_*` hold during the rdy stall.
  - After reset: all outputs 0, both ready outputs 1, state IDLE.
